maxpool_layer_seq: RTL and testbench

//  Sequencer for the 16-lane 2x2/stride-2 maxpool layer array.
//  - Runs NUM_PASSES channel-group passes per layer invocation.
//  - Each pass gates IMG_SIZE*IMG_SIZE input words from the feature buffer into the pool array.
//  - Counts the (IMG_SIZE/2)^2 pooled results coming back, then clears the array between passes.
//  - Signals done after the last pass.
//  - Controls the valid path only; the 512-bit data bus bypasses this block.

---
 rtl/yolo_pkg.sv | 27 ++
 rtl/seq_counter.sv | 37 +++
 rtl/maxpool_layer_seq.sv | 218 +++++++++++++++++++++
 tb/tb_maxpool_layer_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/yolo_pkg.sv
// Shared definitions for the maxpool layer sequencer.
//
// Contents:
//   LANE_W, LANES   - geometry of the pool array. The data bus bypasses the
//                     sequencer, so these are here for the surrounding layer.
//   seq_state_t     - sequencer state encoding.
//   pooled_words()  - number of pooled results a 2x2/stride-2 pool produces
//                     from a square feature map of the given side.
package yolo_pkg;

  localparam int LANE_W = 32;
  localparam int LANES  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_t;

  function automatic int pooled_words(input int img_size);
    return (img_size / 2) * (img_size / 2);
  endfunction

endpackage

// File: rtl/seq_counter.sv
// Saturating up-counter used for every sequencer count (input words, pooled
// results, drain cycles, pass index).
//
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset, value -> 0
//   clr     in   synchronous clear, value -> 0
//   inc     in   increment by one unless already at MAX
//   value   out  current count, WIDTH bits
//   at_max  out  value == MAX
module seq_counter #(
  parameter int          WIDTH = 8,
  parameter int unsigned MAX   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  // Holding at MAX lets the owner detect "one more event than expected"
  // without the count wrapping back to a plausible small value.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (inc && !at_max) begin
      value <= value + WIDTH'(1);
    end
  end

  assign at_max = (value == MAX_V);

endmodule

// File: rtl/maxpool_layer_seq.sv
// Sequencer for the 16-lane 2x2/stride-2 maxpool layer array.
// Runs NUM_PASSES channel-group passes per invocation. Each pass clears the
// pool array, gates IMG_SIZE^2 input words into it, then waits for the
// (IMG_SIZE/2)^2 pooled results before moving on. Only the valid path runs
// through here; the 512-bit data bus goes straight from buffer to array.
//
// Ports:
//   Clk             in   clock
//   Rst             in   synchronous active-high reset
//   start           in   1-cycle pulse, honoured only when idle
//   src_valid       in   feature buffer presents a word
//   src_ready       out  word accepted when src_valid & src_ready
//   pool_valid_in   out  valid_in of the pool array
//   pool_rst        out  clears the pool array
//   pool_valid_out  in   AND of all lane valid_out
//   pass_idx        out  current pass, 0-based
//   busy            out  high in every state except idle
//   done            out  1-cycle pulse after the final pass
//   err_overflow    out  sticky: more pooled results than expected
//   err_timeout     out  sticky: pooled results did not arrive in time
module maxpool_layer_seq
  import yolo_pkg::*;
#(
  parameter int IMG_SIZE    = 416,
  parameter int NUM_PASSES  = 1,
  parameter int DRAIN_LIMIT = 1024
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic                             start,
  input  logic                             src_valid,
  output logic                             src_ready,
  output logic                             pool_valid_in,
  output logic                             pool_rst,
  input  logic                             pool_valid_out,
  output logic [$clog2(NUM_PASSES+1)-1:0]  pass_idx,
  output logic                             busy,
  output logic                             done,
  output logic                             err_overflow,
  output logic                             err_timeout
);

  localparam int N_IN   = IMG_SIZE * IMG_SIZE;
  localparam int N_OUT  = pooled_words(IMG_SIZE);
  localparam int CNT_W  = $clog2(N_IN + 1);
  localparam int DRN_W  = $clog2(DRAIN_LIMIT + 1);
  localparam int PASS_W = $clog2(NUM_PASSES + 1);

  localparam logic [CNT_W-1:0] LAST_IN    = CNT_W'(N_IN - 1);
  localparam logic [CNT_W-1:0] LAST_OUT   = CNT_W'(N_OUT - 1);
  localparam logic [DRN_W-1:0] LAST_DRAIN = DRN_W'(DRAIN_LIMIT - 1);

  seq_state_t state;
  seq_state_t state_next;

  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [DRN_W-1:0] drain_cnt;
  logic             in_full;
  logic             out_full;
  logic             drain_max;
  logic             last_pass;

  logic accept;
  logic out_ev;
  logic out_full_next;
  logic last_word;
  logic drain_expired;
  logic start_ok;
  logic rst_q;

  assign accept   = src_valid && src_ready;
  assign start_ok = (state == ST_IDLE) && start;

  // Pooled results only count while a pass is actually producing them;
  // stray pulses around clears and pass boundaries are dropped silently.
  assign out_ev = pool_valid_out && ((state == ST_STREAM) || (state == ST_DRAIN));

  // Decisions look at the count as it will be after this cycle, so a final
  // result arriving together with the final input still skips DRAIN.
  assign out_full_next = out_full || (out_ev && (out_cnt == LAST_OUT));
  assign last_word     = accept && (in_cnt == LAST_IN);

  // drain_max is a backstop only: DRAIN is always left at LAST_DRAIN.
  assign drain_expired = (state == ST_DRAIN) &&
                         ((drain_cnt == LAST_DRAIN) || drain_max);

  seq_counter #(.WIDTH(CNT_W), .MAX(N_IN)) u_in_cnt (
    .clk    (Clk),
    .rst    (Rst),
    .clr    (state == ST_CLEAR),
    .inc    (accept),
    .value  (in_cnt),
    .at_max (in_full)
  );

  seq_counter #(.WIDTH(CNT_W), .MAX(N_OUT)) u_out_cnt (
    .clk    (Clk),
    .rst    (Rst),
    .clr    (state == ST_CLEAR),
    .inc    (out_ev),
    .value  (out_cnt),
    .at_max (out_full)
  );

  seq_counter #(.WIDTH(DRN_W), .MAX(DRAIN_LIMIT)) u_drain_cnt (
    .clk    (Clk),
    .rst    (Rst),
    .clr    (state == ST_CLEAR),
    .inc    (state == ST_DRAIN),
    .value  (drain_cnt),
    .at_max (drain_max)
  );

  seq_counter #(.WIDTH(PASS_W), .MAX(NUM_PASSES - 1)) u_pass_cnt (
    .clk    (Clk),
    .rst    (Rst),
    .clr    (start_ok),
    .inc    ((state == ST_NEXT) && !last_pass),
    .value  (pass_idx),
    .at_max (last_pass)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Remembers that the previous cycle was a reset so the pool array gets
  // its clear in the first cycle after reset as well.
  always_ff @(posedge Clk) begin
    rst_q <= Rst;
  end

  // Sticky error flags, wiped at the start of a new invocation.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else if (start_ok) begin
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (out_ev && out_full) begin
        err_overflow <= 1'b1;
      end
      if (!out_full_next && drain_expired) begin
        err_timeout <= 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_next = ST_STREAM;
      end
      ST_STREAM: begin
        if (last_word) begin
          state_next = out_full_next ? ST_NEXT : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_full_next || drain_expired) begin
          state_next = ST_NEXT;
        end
      end
      ST_NEXT: begin
        state_next = last_pass ? ST_DONE : ST_CLEAR;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Moore-style outputs plus the zero-latency valid gating.
  always_comb begin
    src_ready     = 1'b0;
    pool_valid_in = 1'b0;
    pool_rst      = rst_q;
    busy          = 1'b1;
    done          = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_CLEAR: begin
        pool_rst = 1'b1;
      end
      ST_STREAM: begin
        src_ready     = !in_full;
        pool_valid_in = src_valid && !in_full;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_maxpool_layer_seq.sv
// Self-checking bench for maxpool_layer_seq with IMG_SIZE=4, three passes
// and an 8-cycle drain limit. A behavioural pool array turns accepted words
// into pooled-result pulses; a negedge monitor tallies events, and each run
// is compared against counts derived from the layer's geometry.
module tb_maxpool_layer_seq;

  localparam int IMG    = 4;
  localparam int PASSES = 3;
  localparam int DLIM   = 8;
  localparam int N_IN   = IMG * IMG;
  localparam int N_OUT  = (IMG / 2) * (IMG / 2);

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       start = 1'b0;
  logic       src_valid = 1'b0;
  logic       pool_valid_out;
  logic       src_ready;
  logic       pool_valid_in;
  logic       pool_rst;
  logic [1:0] pass_idx;
  logic       busy;
  logic       done;
  logic       err_overflow;
  logic       err_timeout;

  int total = 0;
  int bad   = 0;

  // Pool model mode: 0 normal 2x2 pooling, 1 emits 5 results, 2 emits 3.
  int poolMode = 0;
  int poolCount;

  // Monitor tallies.
  int cyc = 0;
  int readyTotal = 0;
  int accTotal = 0;
  int pviTotal = 0;
  int pviBad = 0;
  int outTotal = 0;
  int doneTotal = 0;
  int clrTotal = 0;
  int pidxBad = 0;
  int wordsBad = 0;
  int accPass = 0;
  int expPidx = 0;
  int lastAccCyc = 0;
  int toLat = -1;
  bit toPrev = 1'b0;

  // Snapshot used by the mid-pass reset scenario.
  int snapAcc;
  int snapDone;
  bit reached;

  always #5 Clk = ~Clk;

  maxpool_layer_seq #(
    .IMG_SIZE    (IMG),
    .NUM_PASSES  (PASSES),
    .DRAIN_LIMIT (DLIM)
  ) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .start          (start),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .pool_valid_in  (pool_valid_in),
    .pool_rst       (pool_rst),
    .pool_valid_out (pool_valid_out),
    .pass_idx       (pass_idx),
    .busy           (busy),
    .done           (done),
    .err_overflow   (err_overflow),
    .err_timeout    (err_timeout)
  );

  // Word k of a raster-ordered map completes a 2x2 window when it sits on
  // an odd row and an odd column.
  function automatic bit poolEmits(input int k, input int mode);
    bit r;
    case (mode)
      1:       r = (k < 5);
      2:       r = (k == 5) || (k == 7) || (k == 13);
      default: r = (((k / IMG) % 2) == 1) && (((k % IMG) % 2) == 1);
    endcase
    return r;
  endfunction

  function automatic int outsPerPass(input int mode);
    int n = 0;
    for (int k = 0; k < N_IN; k++) begin
      if (poolEmits(k, mode)) n++;
    end
    return n;
  endfunction

  // Behavioural pool array: one-cycle latency from the completing word.
  always @(posedge Clk) begin
    if (Rst || pool_rst) begin
      poolCount      <= 0;
      pool_valid_out <= 1'b0;
    end else begin
      pool_valid_out <= pool_valid_in && poolEmits(poolCount, poolMode);
      if (pool_valid_in) poolCount <= poolCount + 1;
    end
  end

  // Mid-cycle monitor: tallies accepts, clears, pass indices and errors.
  always @(negedge Clk) begin
    cyc++;
    if (src_ready === 1'b1) readyTotal++;
    if (src_valid && src_ready === 1'b1) begin
      accTotal++;
      accPass++;
      lastAccCyc = cyc;
    end
    if (pool_valid_in !== (src_valid && src_ready)) pviBad++;
    if (pool_valid_in === 1'b1) pviTotal++;
    if (pool_valid_out === 1'b1) outTotal++;
    if (done === 1'b1) begin
      doneTotal++;
      if (accPass != N_IN) wordsBad++;
      if (pass_idx !== 2'(PASSES - 1)) pidxBad++;
      expPidx = 0;
    end
    if (Rst) begin
      expPidx = 0;
      accPass = 0;
    end else if (pool_rst === 1'b1 && busy === 1'b1) begin
      clrTotal++;
      if (expPidx != 0 && accPass != N_IN) wordsBad++;
      if (pass_idx !== 2'(expPidx)) pidxBad++;
      expPidx++;
      accPass = 0;
    end else if (pool_rst === 1'b1) begin
      accPass = 0;
    end
    if (err_timeout === 1'b1 && !toPrev) toLat = cyc - lastAccCyc;
    toPrev = (err_timeout === 1'b1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One full layer invocation. pat: 0 held valid, 1 toggling, 2 random.
  task automatic applyStimulus(input int mode, input int pat, input bit pokeStart);
    int a0, p0, r0, o0, c0, d0, vb0, ib0, wb0;
    bit seenDone;
    poolMode = mode;
    a0 = accTotal;  p0 = pviTotal; r0 = readyTotal; o0 = outTotal;
    c0 = clrTotal;  d0 = doneTotal; vb0 = pviBad;   ib0 = pidxBad;
    wb0 = wordsBad;
    @(posedge Clk); #1;
    start = 1'b1;
    src_valid = 1'b0;
    @(posedge Clk); #1;
    start = 1'b0;
    seenDone = 1'b0;
    for (int i = 0; i < 1000 && !seenDone; i++) begin
      case (pat)
        0:       src_valid = 1'b1;
        1:       src_valid = i[0];
        default: src_valid = ($urandom_range(0, 3) != 0);
      endcase
      start = pokeStart && (i == 12);
      @(posedge Clk); #1;
      if (done) seenDone = 1'b1;
    end
    start = 1'b0;
    checkOutput("done_reached", seenDone, 1);
    repeat (6) begin
      src_valid = ($urandom_range(0, 1) != 0);
      @(posedge Clk); #1;
    end
    src_valid = 1'b0;
    checkOutput("busy_after_done", busy, 0);
    checkOutput("words_accepted", accTotal - a0, PASSES * N_IN);
    checkOutput("pool_valid_in_pulses", pviTotal - p0, PASSES * N_IN);
    checkOutput("pool_valid_in_rule", pviBad - vb0, 0);
    checkOutput("clears", clrTotal - c0, PASSES);
    checkOutput("pass_idx_sequence", pidxBad - ib0, 0);
    checkOutput("words_per_pass", wordsBad - wb0, 0);
    checkOutput("pool_outputs", outTotal - o0, PASSES * outsPerPass(mode));
    checkOutput("done_pulses", doneTotal - d0, 1);
    checkOutput("err_overflow", err_overflow, (mode == 1) ? 1 : 0);
    checkOutput("err_timeout", err_timeout, (mode == 2) ? 1 : 0);
    if (pat == 0) checkOutput("ready_cycles", readyTotal - r0, PASSES * N_IN);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_src_ready", src_ready, 0);
    checkOutput("reset_pool_valid_in", pool_valid_in, 0);
    checkOutput("reset_pass_idx", pass_idx, 0);
    checkOutput("reset_err_overflow", err_overflow, 0);
    checkOutput("reset_err_timeout", err_timeout, 0);
    checkOutput("reset_pool_rst", pool_rst, 1);
    Rst = 1'b0;
    @(posedge Clk); #1;
    checkOutput("idle_pool_rst", pool_rst, 0);

    applyStimulus(0, 0, 1'b0);
    applyStimulus(0, 1, 1'b0);
    applyStimulus(0, 2, 1'b0);
    applyStimulus(1, 2, 1'b0);
    applyStimulus(2, 0, 1'b0);
    checkOutput("timeout_latency", toLat, DLIM + 1);
    applyStimulus(0, 2, 1'b1);

    // Reset in the middle of a pass, once seven words have been taken.
    poolMode = 0;
    snapAcc  = accTotal;
    snapDone = doneTotal;
    @(posedge Clk); #1;
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    src_valid = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(posedge Clk); #1;
      if (accTotal - snapAcc == 7) reached = 1'b1;
    end
    checkOutput("reach_seven_words", reached, 1);
    Rst = 1'b1;
    src_valid = 1'b0;
    @(posedge Clk); #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_src_ready", src_ready, 0);
    checkOutput("midrst_pool_rst", pool_rst, 1);
    checkOutput("midrst_pass_idx", pass_idx, 0);
    Rst = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    checkOutput("midrst_no_done", doneTotal - snapDone, 0);
    checkOutput("midrst_still_idle", busy, 0);
    applyStimulus(0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
